// File: rtl/uart_digit_scanner.sv
// Digit shift buffer fed by a UART byte stream, time-multiplexed onto a
// common-segment multi-digit 7-segment display with anti-ghosting blanking.
module uart_digit_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 12000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            bad_cnt
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [3:0]  Blank = 4'hF;

  logic [3:0]            digits_q [NUM_DIGITS];
  logic [3:0]            digits_d [NUM_DIGITS];
  logic [7:0]            bad_q, bad_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  cnt_wrap;
  logic [NUM_DIGITS-1:0] one_hot;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // Byte handling: digits shift in at index 0, backspace shifts back out.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) digits_d[k] = digits_q[k];
    bad_d = bad_q;
    if (rx_valid) begin
      if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
        for (int k = NUM_DIGITS - 1; k >= 1; k--) digits_d[k] = digits_q[k-1];
        digits_d[0] = rx_byte[3:0];
      end else if (rx_byte == 8'h08) begin
        for (int k = 0; k < NUM_DIGITS - 1; k++) digits_d[k] = digits_q[k+1];
        digits_d[NUM_DIGITS-1] = Blank;
      end else if (rx_byte == 8'h43 || rx_byte == 8'h63) begin
        for (int k = 0; k < NUM_DIGITS; k++) digits_d[k] = Blank;
      end else if (bad_q != 8'hFF) begin
        bad_d = bad_q + 8'd1;
      end
    end
  end

  // Scan: anodes stay dark for the first BLANK_CYC cycles of every dwell.
  always_comb begin
    cnt_wrap = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    one_hot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    an_d     = (cnt_q < CntW'(BLANK_CYC)) ? '1 : ~one_hot;
    seg_d    = decode(digits_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) digits_q[k] <= Blank;
      bad_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) digits_q[k] <= digits_d[k];
      bad_q <= bad_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bad_cnt = bad_q;

endmodule

// File: tb/tb_uart_digit_scanner.sv
// Directed bench for uart_digit_scanner (4 digits, 8-cycle dwell, 2 blank cycles).
module tb_uart_digit_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [7:0] bad_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  uart_digit_scanner #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .seg     (seg),
    .an      (an),
    .bad_cnt (bad_cnt)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected anodes after c edges: registered from the counter state one edge earlier.
  function automatic logic [3:0] exp_an(input int c);
    int j;
    logic [3:0] one;
    if (c == 0) return 4'b1111;
    j = c - 1;
    if ((j % 8) < 2) return 4'b1111;
    one = 4'b0001 << ((j / 8) % 4);
    return ~one;
  endfunction

  function automatic bit lit_idx(input int c, input int i);
    if (c == 0) return 1'b0;
    return (((c - 1) % 8) >= 2) && ((((c - 1) / 8) % 4) == i);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("an_scan", {4'b0, an}, {4'b0, exp_an(cyc)});
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Step until digit i is lit, then compare seg.
  task automatic show(input int i, input logic [6:0] e, input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      if (lit_idx(cyc, i)) begin
        chk(tag, {1'b0, seg}, {1'b0, e});
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed timeout expected digit %0d lit", tag, i);
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_an", {4'b0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_bad", bad_cnt, 8'h00);
    rst_n = 1'b1;

    // 1. Idle scan.
    for (int n = 0; n < 64; n++) begin
      step();
      chk("idle_seg", {1'b0, seg}, 8'h00);
      chk("idle_bad", bad_cnt, 8'h00);
    end

    // 2. '1','2','3','4' -> buffer {1,2,3,4} from idx3 down to idx0.
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    show(3, 7'b0110000, "d3_is_1");
    show(0, 7'b0110011, "d0_is_4");
    show(1, 7'b1111001, "d1_is_3");
    show(2, 7'b1101101, "d2_is_2");
    chk("valid_bad", bad_cnt, 8'h00);

    // 3. '5' shifts out the oldest digit.
    send(8'h35);
    show(3, 7'b1101101, "d3_is_2");
    show(0, 7'b1011011, "d0_is_5");

    // 4. Backspace -> {BLANK,2,3,4}, then clear.
    send(8'h08);
    show(3, 7'b0000000, "bs_d3_blank");
    show(0, 7'b0110011, "bs_d0_is_4");
    show(2, 7'b1101101, "bs_d2_is_2");
    send(8'h43);
    for (int i = 0; i < 4; i++) show(i, 7'b0000000, "clr_blank");

    // Lowercase clear and a digit ignored while rx_valid is low.
    send(8'h37);
    show(0, 7'b1110000, "d0_is_7");
    send(8'h63);
    show(0, 7'b0000000, "clr_lower");
    send(8'h37);
    rx_byte = 8'h39;
    repeat (5) step();
    show(0, 7'b1110000, "novalid_d0");
    show(1, 7'b0000000, "novalid_d1");

    // 5. Held rx_valid with 'x': one bad byte per cycle, saturating.
    rx_byte  = 8'h78;
    rx_valid = 1'b1;
    repeat (100) step();
    rx_valid = 1'b0;
    step();
    chk("bad_100", bad_cnt, 8'd100);
    rx_valid = 1'b1;
    repeat (200) step();
    rx_valid = 1'b0;
    step();
    chk("bad_sat", bad_cnt, 8'hFF);
    show(0, 7'b1110000, "bad_keep_d0");
    show(1, 7'b0000000, "bad_keep_d1");

    // 6. Asynchronous reset mid-dwell while an=1011.
    show(2, 7'b0000000, "pre_rst_d2");
    step();
    chk("pre_rst_an", {4'b0, an}, 8'b0000_1011);
    #3 rst_n = 1'b0;
    #1;
    chk("async_an", {4'b0, an}, 8'h0F);
    chk("async_seg", {1'b0, seg}, 8'h00);
    chk("async_bad", bad_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_an", {4'b0, an}, 8'h0F);
    for (int n = 0; n < 12; n++) step();
    show(0, 7'b0000000, "rst_d0_blank");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
